decode_stage: RTL and testbench

- ID stage of the 5-stage MIPS pipeline, between fetch (IF/ID) and execute (ID/EX).
- Consumes the 64-bit IF/ID bundle: [63:32] = PC+4, [31:0] = instruction.
- Contains the architectural register file (written back from WB), main control decode, sign extension and load-use hazard detection.
- Registers the ID/EX bundle in the exact field layout execute consumes (WB[1:0], M[2:0], EX[3:0], PC+4, two reg operands, sign-extended offset, rt, rd), plus rs for forwarding.

---
 rtl/mips_pkg.sv | 93 +++++++++
 rtl/decode_regfile.sv | 61 ++++++
 rtl/decode_stage.sv | 150 +++++++++++++++
 tb/tb_decode_stage.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mips_pkg
//  Purpose  : Shared definitions for the MIPS pipeline: opcodes, control
//             field bit positions, ALUOp encodings, the control bundle type
//             and the main-control decode function.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package mips_pkg;

    // Opcodes handled by the main control unit
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    // WB field bits
    localparam int WB_REGWRITE = 1;
    localparam int WB_MEMTOREG = 0;

    // M field bits
    localparam int M_BRANCH    = 2;
    localparam int M_MEMREAD   = 1;
    localparam int M_MEMWRITE  = 0;

    // EX field bits
    localparam int EX_ALUOP_HI = 3;
    localparam int EX_ALUOP_LO = 2;
    localparam int EX_REGDST   = 1;
    localparam int EX_ALUSRC   = 0;

    // ALUOp encodings, shared with execute and the ALU control unit
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    typedef struct packed {
        logic [1:0] wb;
        logic [2:0] m;
        logic [3:0] ex;
        logic       illegal;
    } ctrl_t;

    localparam ctrl_t CTRL_NONE = '0;

    // Main control decode. Unsupported opcodes produce no control activity
    // and raise the illegal flag.
    function automatic ctrl_t decode_ctrl(input logic [5:0] opcode);
        ctrl_t c;
        c = CTRL_NONE;
        case (opcode)
            OP_RTYPE: begin
                c.wb[WB_REGWRITE]               = 1'b1;
                c.ex[EX_ALUOP_HI:EX_ALUOP_LO]   = ALUOP_FUNCT;
                c.ex[EX_REGDST]                 = 1'b1;
            end
            OP_LW: begin
                c.wb[WB_REGWRITE]               = 1'b1;
                c.wb[WB_MEMTOREG]               = 1'b1;
                c.m[M_MEMREAD]                  = 1'b1;
                c.ex[EX_ALUOP_HI:EX_ALUOP_LO]   = ALUOP_ADD;
                c.ex[EX_ALUSRC]                 = 1'b1;
            end
            OP_SW: begin
                c.m[M_MEMWRITE]                 = 1'b1;
                c.ex[EX_ALUOP_HI:EX_ALUOP_LO]   = ALUOP_ADD;
                c.ex[EX_ALUSRC]                 = 1'b1;
            end
            OP_BEQ: begin
                c.m[M_BRANCH]                   = 1'b1;
                c.ex[EX_ALUOP_HI:EX_ALUOP_LO]   = ALUOP_SUB;
            end
            OP_ADDI: begin
                c.wb[WB_REGWRITE]               = 1'b1;
                c.ex[EX_ALUOP_HI:EX_ALUOP_LO]   = ALUOP_ADD;
                c.ex[EX_ALUSRC]                 = 1'b1;
            end
            default: begin
                c.illegal                       = 1'b1;
            end
        endcase
        return c;
    endfunction

    // Instructions whose rt field is a source operand (not a destination)
    function automatic logic reads_rt(input logic [5:0] opcode);
        return (opcode == OP_RTYPE) || (opcode == OP_SW) || (opcode == OP_BEQ);
    endfunction

endpackage
`default_nettype wire

// File: rtl/decode_regfile.sv
`default_nettype none
// ============================================================================
//  Module   : decode_regfile
//  Purpose  : 32 x 32-bit architectural register file. Two combinational
//             read ports, one synchronous write port, $0 hardwired to zero,
//             and write-through bypass so a read of the register being
//             written this cycle returns the new data.
//  Ports    : clk_i, rst_i          - clock, synchronous active-high reset
//             raddr1_i/rdata1_o     - read port 1
//             raddr2_i/rdata2_o     - read port 2
//             we_i/waddr_i/wdata_i  - write port (from WB)
//  Revision : 1.0 - initial release
// ============================================================================
module decode_regfile (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [4:0]  raddr1_i,
    input  logic [4:0]  raddr2_i,
    output logic [31:0] rdata1_o,
    output logic [31:0] rdata2_o,
    input  logic        we_i,
    input  logic [4:0]  waddr_i,
    input  logic [31:0] wdata_i
);

    logic [31:0] mem_q [32];
    logic        write_en;

    // Writes to $0 are discarded so it always reads back zero
    assign write_en = we_i && (waddr_i != 5'd0);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < 32; i++) begin
                mem_q[i] <= '0;
            end
        end else if (write_en) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    always_comb begin
        rdata1_o = mem_q[raddr1_i];
        if (raddr1_i == 5'd0) begin
            rdata1_o = '0;
        end else if (write_en && (waddr_i == raddr1_i)) begin
            rdata1_o = wdata_i;
        end
    end

    always_comb begin
        rdata2_o = mem_q[raddr2_i];
        if (raddr2_i == 5'd0) begin
            rdata2_o = '0;
        end else if (write_en && (waddr_i == raddr2_i)) begin
            rdata2_o = wdata_i;
        end
    end

endmodule
`default_nettype wire

// File: rtl/decode_stage.sv
`default_nettype none
// ============================================================================
//  Module   : decode_stage
//  Purpose  : ID stage of the 5-stage MIPS pipeline. Reads operands from the
//             register file, decodes main control, sign-extends the
//             immediate, detects load-use hazards and registers the ID/EX
//             bundle consumed by execute.
//  Ports    : clk, reset               - clock, synchronous active-high reset
//             in_IF_ID                  - {PC+4, instruction}
//             in_wb_reg_write/_write_reg/_write_data - WB write-back port
//             in_flush                  - squash the instruction in ID
//             out_pc_write, out_if_id_write - fetch hold controls (0 = hold)
//             out_WB/out_M/out_EX       - registered control fields
//             out_incremented_PC        - registered PC+4
//             out_regData1/2            - registered rs/rt operand values
//             out_sign_extended_offset  - registered sign-extended imm
//             out_rs/out_rt/out_rd      - registered register numbers
//             out_illegal               - registered unsupported-opcode flag
//  Revision : 1.0 - initial release
// ============================================================================
module decode_stage
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC_INC = 32'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [63:0] in_IF_ID,
    input  logic        in_wb_reg_write,
    input  logic [4:0]  in_wb_write_reg,
    input  logic [31:0] in_wb_write_data,
    input  logic        in_flush,
    output logic        out_pc_write,
    output logic        out_if_id_write,
    output logic [1:0]  out_WB,
    output logic [2:0]  out_M,
    output logic [3:0]  out_EX,
    output logic [31:0] out_incremented_PC,
    output logic [31:0] out_regData1,
    output logic [31:0] out_regData2,
    output logic [31:0] out_sign_extended_offset,
    output logic [4:0]  out_rs,
    output logic [4:0]  out_rt,
    output logic [4:0]  out_rd,
    output logic        out_illegal
);

    // IF/ID field extraction
    logic [31:0] pc_inc;
    logic [31:0] instr;
    logic [5:0]  opcode;
    logic [4:0]  instr_rs;
    logic [4:0]  instr_rt;
    logic [4:0]  instr_rd;

    assign pc_inc   = in_IF_ID[63:32];
    assign instr    = in_IF_ID[31:0];
    assign opcode   = instr[31:26];
    assign instr_rs = instr[25:21];
    assign instr_rt = instr[20:16];
    assign instr_rd = instr[15:11];

    // ID/EX pipeline register
    ctrl_t       ctrl_q,   ctrl_d;
    logic [31:0] pc_q,     pc_d;
    logic [31:0] data1_q,  data1_d;
    logic [31:0] data2_q,  data2_d;
    logic [31:0] offset_q, offset_d;
    logic [4:0]  rs_q,     rs_d;
    logic [4:0]  rt_q,     rt_d;
    logic [4:0]  rd_q,     rd_d;

    logic [31:0] rf_rdata1;
    logic [31:0] rf_rdata2;
    logic        stall;

    decode_regfile u_regfile (
        .clk_i    (clk),
        .rst_i    (reset),
        .raddr1_i (instr_rs),
        .raddr2_i (instr_rt),
        .rdata1_o (rf_rdata1),
        .rdata2_o (rf_rdata2),
        .we_i     (in_wb_reg_write),
        .waddr_i  (in_wb_write_reg),
        .wdata_i  (in_wb_write_data)
    );

    // Load-use hazard: the load now in EX writes a register this
    // instruction reads. rt only counts where it is a source operand.
    assign stall = ctrl_q.m[M_MEMREAD]
                && (rt_q != 5'd0)
                && ((rt_q == instr_rs)
                    || ((rt_q == instr_rt) && reads_rt(opcode)));

    // Flush wins over stall so fetch is free to redirect to the branch target
    assign out_pc_write    = reset | in_flush | ~stall;
    assign out_if_id_write = reset | in_flush | ~stall;

    always_comb begin
        ctrl_d   = decode_ctrl(opcode);
        pc_d     = pc_inc;
        data1_d  = rf_rdata1;
        data2_d  = rf_rdata2;
        offset_d = {{16{instr[15]}}, instr[15:0]};
        rs_d     = instr_rs;
        rt_d     = instr_rt;
        rd_d     = instr_rd;
        // Bubble: data fields still load, only control is squashed
        if (stall || in_flush) begin
            ctrl_d = CTRL_NONE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_q   <= CTRL_NONE;
            pc_q     <= RESET_PC_INC;
            data1_q  <= '0;
            data2_q  <= '0;
            offset_q <= '0;
            rs_q     <= '0;
            rt_q     <= '0;
            rd_q     <= '0;
        end else begin
            ctrl_q   <= ctrl_d;
            pc_q     <= pc_d;
            data1_q  <= data1_d;
            data2_q  <= data2_d;
            offset_q <= offset_d;
            rs_q     <= rs_d;
            rt_q     <= rt_d;
            rd_q     <= rd_d;
        end
    end

    assign out_WB                   = ctrl_q.wb;
    assign out_M                    = ctrl_q.m;
    assign out_EX                   = ctrl_q.ex;
    assign out_illegal              = ctrl_q.illegal;
    assign out_incremented_PC       = pc_q;
    assign out_regData1             = data1_q;
    assign out_regData2             = data2_q;
    assign out_sign_extended_offset = offset_q;
    assign out_rs                   = rs_q;
    assign out_rt                   = rt_q;
    assign out_rd                   = rd_q;

endmodule
`default_nettype wire

// File: tb/tb_decode_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_decode_stage
//  Purpose  : Self-checking bench for decode_stage. A behavioural model
//             (register array, control table, hazard rule) predicts the
//             ID/EX bundle every cycle; directed steps pin known values and
//             a randomized phase exercises hazards, bypass, flush and reset.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] if_id;
    logic        wb_we;
    logic [4:0]  wb_reg;
    logic [31:0] wb_data;
    logic        flush;

    logic        pc_write, if_id_write;
    logic [1:0]  o_wb;
    logic [2:0]  o_m;
    logic [3:0]  o_ex;
    logic [31:0] o_pc, o_d1, o_d2, o_off;
    logic [4:0]  o_rs, o_rt, o_rd;
    logic        o_ill;

    always #5 clk = ~clk;

    decode_stage #(.RESET_PC_INC(32'd0)) dut (
        .clk                      (clk),
        .reset                    (reset),
        .in_IF_ID                 (if_id),
        .in_wb_reg_write          (wb_we),
        .in_wb_write_reg          (wb_reg),
        .in_wb_write_data         (wb_data),
        .in_flush                 (flush),
        .out_pc_write             (pc_write),
        .out_if_id_write          (if_id_write),
        .out_WB                   (o_wb),
        .out_M                    (o_m),
        .out_EX                   (o_ex),
        .out_incremented_PC       (o_pc),
        .out_regData1             (o_d1),
        .out_regData2             (o_d2),
        .out_sign_extended_offset (o_off),
        .out_rs                   (o_rs),
        .out_rt                   (o_rt),
        .out_rd                   (o_rd),
        .out_illegal              (o_ill)
    );

    // ------------------------------------------------------------------
    // Behavioural model
    // ------------------------------------------------------------------
    logic [31:0] m_rf [32];
    logic [1:0]  e_wb;
    logic [2:0]  e_m;
    logic [3:0]  e_ex;
    logic [31:0] e_pc, e_d1, e_d2, e_off;
    logic [4:0]  e_rs, e_rt, e_rd;
    logic        e_ill;
    logic        model_valid = 1'b0;

    // {WB, M, EX, illegal} straight from the opcode table
    function automatic logic [9:0] ctrl_of(input logic [5:0] op);
        case (op)
            6'h00:   return {2'b10, 3'b000, 4'b1010, 1'b0};
            6'h23:   return {2'b11, 3'b010, 4'b0001, 1'b0};
            6'h2B:   return {2'b00, 3'b001, 4'b0001, 1'b0};
            6'h04:   return {2'b00, 3'b100, 4'b0100, 1'b0};
            6'h08:   return {2'b10, 3'b000, 4'b0001, 1'b0};
            default: return {9'd0, 1'b1};
        endcase
    endfunction

    function automatic logic [31:0] model_read(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
        if (wb_we && wb_reg == a) return wb_data;
        return m_rf[a];
    endfunction

    function automatic logic model_stall();
        logic [5:0] op;
        logic       uses_rt;
        op      = if_id[31:26];
        uses_rt = (op == 6'h00) || (op == 6'h2B) || (op == 6'h04);
        return e_m[1] && (e_rt != 5'd0) &&
               ((e_rt == if_id[25:21]) || (e_rt == if_id[20:16] && uses_rt));
    endfunction

    always @(posedge clk) begin
        logic [9:0] c;
        if (reset) begin
            for (int i = 0; i < 32; i++) m_rf[i] <= 32'd0;
            {e_wb, e_m, e_ex, e_ill} <= 10'd0;
            e_pc  <= 32'd0;
            e_d1  <= 32'd0;
            e_d2  <= 32'd0;
            e_off <= 32'd0;
            e_rs  <= 5'd0;
            e_rt  <= 5'd0;
            e_rd  <= 5'd0;
            model_valid <= 1'b1;
        end else if (model_valid) begin
            c = ctrl_of(if_id[31:26]);
            if (model_stall() || flush) c = 10'd0;
            {e_wb, e_m, e_ex, e_ill} <= c;
            e_pc  <= if_id[63:32];
            e_d1  <= model_read(if_id[25:21]);
            e_d2  <= model_read(if_id[20:16]);
            e_off <= 32'(signed'(if_id[15:0]));
            e_rs  <= if_id[25:21];
            e_rt  <= if_id[20:16];
            e_rd  <= if_id[15:11];
            if (wb_we && wb_reg != 5'd0) m_rf[wb_reg] <= wb_data;
        end
    end

    // ------------------------------------------------------------------
    // Checking
    // ------------------------------------------------------------------
    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Registered ID/EX bundle against the model
    task automatic cmp_regs();
        if (model_valid) begin
            check("WB",     32'(o_wb),  32'(e_wb));
            check("M",      32'(o_m),   32'(e_m));
            check("EX",     32'(o_ex),  32'(e_ex));
            check("illegal",32'(o_ill), 32'(e_ill));
            check("pc_inc", o_pc,       e_pc);
            check("data1",  o_d1,       e_d1);
            check("data2",  o_d2,       e_d2);
            check("offset", o_off,      e_off);
            check("rs",     32'(o_rs),  32'(e_rs));
            check("rt",     32'(o_rt),  32'(e_rt));
            check("rd",     32'(o_rd),  32'(e_rd));
        end
    endtask

    // Apply inputs just after a rising edge, then check the hold controls
    task automatic drive(input logic [63:0] ifid, input logic we, input logic [4:0] wr,
                         input logic [31:0] wd, input logic fl, input logic rst);
        logic exp_w;
        if_id   = ifid;
        wb_we   = we;
        wb_reg  = wr;
        wb_data = wd;
        flush   = fl;
        reset   = rst;
        #1;
        if (model_valid) begin
            exp_w = rst || fl || !model_stall();
            check("pc_write",    32'(pc_write),    32'(exp_w));
            check("if_id_write", 32'(if_id_write), 32'(exp_w));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cmp_regs();
    endtask

    localparam logic [31:0] I_NOP      = 32'h0000_0000;
    localparam logic [31:0] I_ADD_312  = 32'h0022_1820; // add $3,$1,$2
    localparam logic [31:0] I_LW_M4    = 32'h8C24_FFFC; // lw $4,-4($1)
    localparam logic [31:0] I_LW_0     = 32'h8C24_0000; // lw $4,0($1)
    localparam logic [31:0] I_ADD_541  = 32'h0081_2820; // add $5,$4,$1
    localparam logic [31:0] I_ADD_612  = 32'h0022_3020; // add $6,$1,$2
    localparam logic [31:0] I_ADD_760  = 32'h00C0_3820; // add $7,$6,$0
    localparam logic [31:0] I_ADD_800  = 32'h0000_4020; // add $8,$0,$0
    localparam logic [31:0] I_SW       = 32'hAC22_0004; // sw $2,4($1)
    localparam logic [31:0] I_BEQ      = 32'h1022_0003; // beq $1,$2,3
    localparam logic [31:0] I_ADDI     = 32'h2023_0005; // addi $3,$1,5
    localparam logic [31:0] I_ILLEGAL  = 32'hFC00_0000;

    initial begin
        logic [63:0] cur;
        logic        hold;
        logic [5:0]  op;
        logic [5:0]  ops [5];
        ops[0] = 6'h00; ops[1] = 6'h23; ops[2] = 6'h2B; ops[3] = 6'h04; ops[4] = 6'h08;

        // Reset
        drive({32'd4, I_NOP}, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1);
        tick();
        tick();
        check("rst WB",       32'(o_wb), 32'h0);
        check("rst pc_inc",   o_pc,      32'h0);
        check("rst data1",    o_d1,      32'h0);

        // Preload $1 = 5, $2 = 7
        drive({32'd4, I_NOP}, 1'b1, 5'd1, 32'd5, 1'b0, 1'b0);
        check("post-rst pc_write", 32'(pc_write), 32'h1);
        tick();
        drive({32'd4, I_NOP}, 1'b1, 5'd2, 32'd7, 1'b0, 1'b0);
        tick();

        // add $3,$1,$2
        drive({32'd8, I_ADD_312}, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
        tick();
        check("add WB",    32'(o_wb), 32'h2);
        check("add M",     32'(o_m),  32'h0);
        check("add EX",    32'(o_ex), 32'hA);
        check("add data1", o_d1,      32'd5);
        check("add data2", o_d2,      32'd7);
        check("add rs",    32'(o_rs), 32'd1);
        check("add rt",    32'(o_rt), 32'd2);
        check("add rd",    32'(o_rd), 32'd3);
        check("add pc",    o_pc,      32'd8);

        // lw $4,-4($1)
        drive({32'd12, I_LW_M4}, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
        tick();
        check("lw offset", o_off,      32'hFFFF_FFFC);
        check("lw WB",     32'(o_wb),  32'h3);
        check("lw M",      32'(o_m),   32'h2);
        check("lw EX",     32'(o_ex),  32'h1);
        check("lw rt",     32'(o_rt),  32'd4);

        // lw $4 after lw $4: rt is a destination of lw, no stall
        drive({32'd16, I_LW_0}, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
        check("lw-lw pc_write", 32'(pc_write), 32'h1);
        tick();

        // Load-use: add $5,$4,$1 stalls for one cycle
        drive({32'd20, I_ADD_541}, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
        check("stall pc_write",    32'(pc_write),    32'h0);
        check("stall if_id_write", 32'(if_id_write), 32'h0);
        tick();
        check("bubble ctrl", 32'({o_wb, o_m, o_ex, o_ill}), 32'h0);
        check("bubble rd",   32'(o_rd), 32'd5);
        drive({32'd20, I_ADD_541}, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
        check("after bubble pc_write", 32'(pc_write), 32'h1);
        tick();
        check("add issues WB", 32'(o_wb), 32'h2);

        // Load followed by an independent add: no stall
        drive({32'd24, I_LW_0}, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
        tick();
        drive({32'd28, I_ADD_612}, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
        check("no-dep pc_write", 32'(pc_write), 32'h1);
        tick();

        // Write-through bypass
        drive({32'd32, I_ADD_760}, 1'b1, 5'd6, 32'hDEAD_BEEF, 1'b0, 1'b0);
        tick();
        check("bypass data1", o_d1, 32'hDEAD_BEEF);

        // Write to $0 is ignored, even through the bypass
        drive({32'd36, I_ADD_800}, 1'b1, 5'd0, 32'h1234, 1'b0, 1'b0);
        tick();
        check("r0 data1", o_d1, 32'h0);
        drive({32'd40, I_ADD_800}, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
        tick();
        check("r0 data2", o_d2, 32'h0);

        // Flush together with a stall condition
        drive({32'd44, I_LW_0}, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
        tick();
        drive({32'd48, I_ADD_541}, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0);
        check("flush pc_write",    32'(pc_write),    32'h1);
        check("flush if_id_write", 32'(if_id_write), 32'h1);
        tick();
        check("flush ctrl", 32'({o_wb, o_m, o_ex, o_ill}), 32'h0);

        // Remaining opcodes
        drive({32'd52, I_SW}, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
        tick();
        check("sw ctrl", 32'({o_wb, o_m, o_ex}), 32'({2'b00, 3'b001, 4'b0001}));
        drive({32'd56, I_BEQ}, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
        tick();
        check("beq ctrl", 32'({o_wb, o_m, o_ex}), 32'({2'b00, 3'b100, 4'b0100}));
        drive({32'd60, I_ADDI}, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
        tick();
        check("addi ctrl", 32'({o_wb, o_m, o_ex}), 32'({2'b10, 3'b000, 4'b0001}));
        drive({32'd64, I_ILLEGAL}, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
        tick();
        check("illegal flag", 32'(o_ill), 32'h1);
        check("illegal ctrl", 32'({o_wb, o_m, o_ex}), 32'h0);

        // Mid-stream reset clears outputs and registers
        drive({32'd68, I_ADD_312}, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1);
        tick();
        check("mid-rst ctrl",  32'({o_wb, o_m, o_ex, o_ill}), 32'h0);
        check("mid-rst pc",    o_pc,      32'h0);
        check("mid-rst rd",    32'(o_rd), 32'h0);
        drive({32'd72, I_ADD_312}, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
        tick();
        check("cleared $1", o_d1, 32'h0);
        check("cleared $2", o_d2, 32'h0);

        // Randomized phase; IF/ID is held whenever the model predicts a stall
        cur  = {32'd100, I_NOP};
        hold = 1'b0;
        for (int n = 0; n < 600; n++) begin
            logic        we, fl, rst;
            logic [4:0]  wr;
            logic [31:0] wd;
            if (!hold) begin
                if ($urandom_range(0, 5) == 5) op = 6'($urandom);
                else                           op = ops[$urandom_range(0, 4)];
                cur = {$urandom(), op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                       5'($urandom_range(0, 7)), 11'($urandom)};
            end
            we  = ($urandom_range(0, 9) < 4);
            wr  = 5'($urandom_range(0, 7));
            wd  = $urandom();
            fl  = ($urandom_range(0, 9) == 0);
            rst = ($urandom_range(0, 49) == 0);
            drive(cur, we, wr, wd, fl, rst);
            hold = model_valid && model_stall() && !fl && !rst;
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
